// File: rtl/speccfa_block_loader_if.sv
// Byte-stream source and peripheral-bus write port of the SpecCFA block loader.
// The loader is the master side; the host stream / bus fabric is the slave side.
interface speccfa_block_loader_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        bus_gnt;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;

   modport master (
      input  in_data,
      input  in_valid,
      input  bus_gnt,
      output in_ready,
      output per_addr,
      output per_din,
      output per_en,
      output per_we
   );

   modport slave (
      output in_data,
      output in_valid,
      output bus_gnt,
      input  in_ready,
      input  per_addr,
      input  per_din,
      input  per_en,
      input  per_we
   );
endinterface

// File: rtl/speccfa_block_loader.sv
// Fills the SpecCFA block-metadata window from a framed byte stream:
// N, six bytes per block (src, dst, len, id), XOR checksum.
//
// state  | meaning
// S_IDLE | waiting for load_start after reset
// S_HDR  | accept block count N
// S_LO   | accept low byte of the next word
// S_HI   | accept high byte of the next word
// S_WR   | bus write of the assembled word, held until bus_gnt
// S_CHK  | accept and compare checksum byte
// S_DONE | frame finished (meta_valid or chk_err), waiting for re-arm
// S_ERR  | bad block count, waiting for re-arm
module speccfa_block_loader #(
   parameter logic [14:0] BASE_ADDR     = 15'h0400,
   parameter int          MAX_BLOCKS    = 8,
   parameter int          BLOCKMEM_SIZE = 512
) (
   input  logic                          mclk,
   input  logic                          puc_rst_n,
   input  logic                          load_start,
   speccfa_block_loader_if.master        bus,
   output logic                          busy,
   output logic                          done,
   output logic                          meta_valid,
   output logic                          hdr_err,
   output logic                          chk_err,
   output logic [7:0]                    blocks_loaded
);

   if (3 * MAX_BLOCKS > BLOCKMEM_SIZE) begin : g_cfg_check
      $error("speccfa_block_loader: 3*MAX_BLOCKS does not fit in BLOCKMEM_SIZE");
   end

   localparam logic [13:0] WORD_BASE = BASE_ADDR[14:1];
   localparam logic [7:0]  MAX_N     = 8'(MAX_BLOCKS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_LO,
      S_HI,
      S_WR,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  n_q, n_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  hi_q, hi_d;
   logic [7:0]  xor_q, xor_d;
   logic [13:0] word_idx_q, word_idx_d;
   logic [1:0]  word_sel_q, word_sel_d;
   logic [7:0]  blocks_q, blocks_d;
   logic        done_q, done_d;
   logic        meta_q, meta_d;
   logic        hdr_err_q, hdr_err_d;
   logic        chk_err_q, chk_err_d;

   logic        in_ready_w;
   logic        wr_w;
   logic        accept_w;
   logic [7:0]  blocks_inc_w;

   // Handshake outputs are pure functions of state so they can never overlap.
   assign in_ready_w   = (state_q == S_HDR) || (state_q == S_LO) ||
                         (state_q == S_HI)  || (state_q == S_CHK);
   assign wr_w         = (state_q == S_WR);
   assign accept_w     = bus.in_valid & in_ready_w;
   assign blocks_inc_w = blocks_q + 8'd1;

   assign bus.in_ready = in_ready_w;
   assign bus.per_en   = wr_w;
   assign bus.per_we   = wr_w ? 2'b11 : 2'b00;
   assign bus.per_addr = wr_w ? (WORD_BASE + word_idx_q) : 14'd0;
   assign bus.per_din  = wr_w ? {hi_q, lo_q} : 16'd0;

   assign busy          = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
   assign done          = done_q;
   assign meta_valid    = meta_q;
   assign hdr_err       = hdr_err_q;
   assign chk_err       = chk_err_q;
   assign blocks_loaded = blocks_q;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      xor_d      = xor_q;
      word_idx_d = word_idx_q;
      word_sel_d = word_sel_q;
      blocks_d   = blocks_q;
      done_d     = done_q;
      meta_d     = meta_q;
      hdr_err_d  = hdr_err_q;
      chk_err_d  = chk_err_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (load_start) begin
               state_d    = S_HDR;
               done_d     = 1'b0;
               meta_d     = 1'b0;
               hdr_err_d  = 1'b0;
               chk_err_d  = 1'b0;
               blocks_d   = 8'd0;
               xor_d      = 8'd0;
               word_idx_d = 14'd0;
               word_sel_d = 2'd0;
            end
         end

         S_HDR: begin
            if (accept_w) begin
               xor_d = xor_q ^ bus.in_data;
               if ((bus.in_data == 8'd0) || (bus.in_data > MAX_N)) begin
                  hdr_err_d = 1'b1;
                  state_d   = S_ERR;
               end else begin
                  n_d     = bus.in_data;
                  state_d = S_LO;
               end
            end
         end

         S_LO: begin
            if (accept_w) begin
               lo_d    = bus.in_data;
               xor_d   = xor_q ^ bus.in_data;
               state_d = S_HI;
            end
         end

         S_HI: begin
            if (accept_w) begin
               hi_d    = bus.in_data;
               xor_d   = xor_q ^ bus.in_data;
               state_d = S_WR;
            end
         end

         S_WR: begin
            if (bus.bus_gnt) begin
               word_idx_d = word_idx_q + 14'd1;
               if (word_sel_q == 2'd2) begin
                  word_sel_d = 2'd0;
                  blocks_d   = blocks_inc_w;
                  state_d    = (blocks_inc_w == n_q) ? S_CHK : S_LO;
               end else begin
                  word_sel_d = word_sel_q + 2'd1;
                  state_d    = S_LO;
               end
            end
         end

         S_CHK: begin
            if (accept_w) begin
               if (bus.in_data == xor_q) begin
                  meta_d = 1'b1;
               end else begin
                  chk_err_d = 1'b1;
               end
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         state_q    <= S_IDLE;
         n_q        <= 8'd0;
         lo_q       <= 8'd0;
         hi_q       <= 8'd0;
         xor_q      <= 8'd0;
         word_idx_q <= 14'd0;
         word_sel_q <= 2'd0;
         blocks_q   <= 8'd0;
         done_q     <= 1'b0;
         meta_q     <= 1'b0;
         hdr_err_q  <= 1'b0;
         chk_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         xor_q      <= xor_d;
         word_idx_q <= word_idx_d;
         word_sel_q <= word_sel_d;
         blocks_q   <= blocks_d;
         done_q     <= done_d;
         meta_q     <= meta_d;
         hdr_err_q  <= hdr_err_d;
         chk_err_q  <= chk_err_d;
      end
   end

endmodule

// File: tb/tb_speccfa_block_loader.sv
// Directed frame vectors for the SpecCFA block loader, plus reset-abort sequence.
module tb_speccfa_block_loader;

   localparam int NV = 8;

   typedef struct packed {
      logic [15:0][7:0]  bytes;
      int                nbytes;
      int                stall;
      logic              gap;
      logic              midstart;
      int                nwr;
      logic [5:0][13:0]  wa;
      logic [5:0][15:0]  wd;
      logic              e_done;
      logic              e_meta;
      logic              e_hdr;
      logic              e_chk;
      logic [7:0]        e_blk;
      int                e_cyc;
   } vec_t;

   vec_t vecs [NV];

   logic       mclk = 1'b0;
   logic       puc_rst_n;
   logic       load_start;
   logic       busy, done, meta_valid, hdr_err, chk_err;
   logic [7:0] blocks_loaded;

   int n_vec = 0;
   int n_err = 0;

   speccfa_block_loader_if bus_if ();

   speccfa_block_loader dut (
      .mclk          (mclk),
      .puc_rst_n     (puc_rst_n),
      .load_start    (load_start),
      .bus           (bus_if.master),
      .busy          (busy),
      .done          (done),
      .meta_valid    (meta_valid),
      .hdr_err       (hdr_err),
      .chk_err       (chk_err),
      .blocks_loaded (blocks_loaded)
   );

   always #5 mclk = ~mclk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_byte(input int i, input logic [7:0] b);
      vecs[i].bytes[vecs[i].nbytes] = b;
      vecs[i].nbytes = vecs[i].nbytes + 1;
   endtask

   task automatic add_wr(input int i, input logic [13:0] a, input logic [15:0] d);
      vecs[i].wa[vecs[i].nwr] = a;
      vecs[i].wd[vecs[i].nwr] = d;
      vecs[i].nwr = vecs[i].nwr + 1;
   endtask

   task automatic set_exp(input int i, input logic d, input logic m, input logic h,
                          input logic c, input logic [7:0] blk, input int cyc);
      vecs[i].e_done = d;
      vecs[i].e_meta = m;
      vecs[i].e_hdr  = h;
      vecs[i].e_chk  = c;
      vecs[i].e_blk  = blk;
      vecs[i].e_cyc  = cyc;
   endtask

   // N=1 frame: src 0x1234, dst 0x5678, len 05, id 02; correct checksum is 0E
   task automatic one_block(input int i, input logic [7:0] chk);
      add_byte(i, 8'h01);
      add_byte(i, 8'h34); add_byte(i, 8'h12);
      add_byte(i, 8'h78); add_byte(i, 8'h56);
      add_byte(i, 8'h05); add_byte(i, 8'h02);
      add_byte(i, chk);
      add_wr(i, 14'h200, 16'h1234);
      add_wr(i, 14'h201, 16'h5678);
      add_wr(i, 14'h202, 16'h0205);
   endtask

   task automatic fill_table();
      for (int i = 0; i < NV; i++) vecs[i] = '0;
      one_block(0, 8'h0E);
      set_exp(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 12);

      add_byte(1, 8'h09);
      set_exp(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2);

      one_block(2, 8'h0F);
      set_exp(2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 12);

      one_block(3, 8'h0E);
      vecs[3].stall = 3;
      set_exp(3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 15);

      add_byte(4, 8'h02);
      add_byte(4, 8'h00); add_byte(4, 8'h10); add_byte(4, 8'h00);
      add_byte(4, 8'h20); add_byte(4, 8'h08); add_byte(4, 8'h01);
      add_byte(4, 8'h34); add_byte(4, 8'h12); add_byte(4, 8'h78);
      add_byte(4, 8'h56); add_byte(4, 8'h05); add_byte(4, 8'h02);
      add_byte(4, 8'h34);
      add_wr(4, 14'h200, 16'h1000);
      add_wr(4, 14'h201, 16'h2000);
      add_wr(4, 14'h202, 16'h0108);
      add_wr(4, 14'h203, 16'h1234);
      add_wr(4, 14'h204, 16'h5678);
      add_wr(4, 14'h205, 16'h0205);
      set_exp(4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 21);

      add_byte(5, 8'h00);
      set_exp(5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2);

      one_block(6, 8'h0E);
      vecs[6].gap = 1'b1;
      set_exp(6, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 0);

      one_block(7, 8'h0E);
      vecs[7].midstart = 1'b1;
      set_exp(7, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 12);
   endtask

   task automatic run_vec(input int i);
      vec_t        v;
      int          ptr, cyc, nw, stall_left, hold_cnt;
      logic [13:0] ga [8];
      logic [15:0] gd [8];
      logic [13:0] h_a;
      logic [15:0] h_d;
      logic        fin;
      v = vecs[i];
      ptr = 0; cyc = 0; nw = 0; stall_left = v.stall; hold_cnt = 0; fin = 1'b0;
      h_a = '0; h_d = '0;
      @(negedge mclk);
      bus_if.in_valid = 1'b0;
      bus_if.bus_gnt  = 1'b1;
      load_start      = 1'b1;
      @(negedge mclk);
      load_start = 1'b0;
      while (!fin && cyc < 200) begin
         if (cyc > 0) @(negedge mclk);
         cyc = cyc + 1;
         load_start      = v.midstart && (cyc == 5);
         bus_if.in_valid = (ptr < v.nbytes) && !(v.gap && (cyc % 2 == 0));
         bus_if.in_data  = (ptr < v.nbytes) ? v.bytes[ptr] : 8'hA5;
         bus_if.bus_gnt  = (stall_left == 0);
         #1;
         if (cyc == 1) begin
            check($sformatf("v%0d busy_after_start", i), busy, 1);
            check($sformatf("v%0d done_cleared", i), done, 0);
            check($sformatf("v%0d meta_cleared", i), meta_valid, 0);
            check($sformatf("v%0d hdr_cleared", i), hdr_err, 0);
            check($sformatf("v%0d chk_cleared", i), chk_err, 0);
            check($sformatf("v%0d blk_cleared", i), blocks_loaded, 0);
         end
         if (done || hdr_err) begin
            fin = 1'b1;
         end else begin
            check($sformatf("v%0d c%0d ready_en_overlap", i, cyc),
                  bus_if.in_ready & bus_if.per_en, 0);
            if (bus_if.per_en) begin
               check($sformatf("v%0d c%0d per_we", i, cyc), bus_if.per_we, 2'b11);
               if (nw == 0) begin
                  if (hold_cnt == 0) begin
                     h_a = bus_if.per_addr;
                     h_d = bus_if.per_din;
                  end else begin
                     check($sformatf("v%0d hold_addr c%0d", i, cyc), bus_if.per_addr, h_a);
                     check($sformatf("v%0d hold_data c%0d", i, cyc), bus_if.per_din, h_d);
                  end
                  hold_cnt = hold_cnt + 1;
               end
               if (bus_if.bus_gnt) begin
                  if (nw < 8) begin
                     ga[nw] = bus_if.per_addr;
                     gd[nw] = bus_if.per_din;
                  end
                  nw = nw + 1;
               end else begin
                  stall_left = stall_left - 1;
               end
            end
            if (bus_if.in_valid && bus_if.in_ready) ptr = ptr + 1;
         end
      end
      load_start      = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.bus_gnt  = 1'b1;
      check($sformatf("v%0d finished_in_budget", i), fin, 1);
      if (v.e_cyc != 0) check($sformatf("v%0d cycles", i), cyc, v.e_cyc);
      check($sformatf("v%0d write_count", i), nw, v.nwr);
      for (int k = 0; k < v.nwr && k < nw && k < 6; k++) begin
         check($sformatf("v%0d wr%0d addr", i, k), ga[k], v.wa[k]);
         check($sformatf("v%0d wr%0d data", i, k), gd[k], v.wd[k]);
      end
      if (v.nwr > 0) check($sformatf("v%0d first_write_hold", i), hold_cnt, v.stall + 1);
      check($sformatf("v%0d done", i), done, v.e_done);
      check($sformatf("v%0d meta_valid", i), meta_valid, v.e_meta);
      check($sformatf("v%0d hdr_err", i), hdr_err, v.e_hdr);
      check($sformatf("v%0d chk_err", i), chk_err, v.e_chk);
      check($sformatf("v%0d blocks_loaded", i), blocks_loaded, v.e_blk);
      check($sformatf("v%0d busy_end", i), busy, 0);
      for (int c = 0; c < 2; c++) begin
         @(negedge mclk);
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = 8'h01;
         #1;
         check($sformatf("v%0d idle_in_ready", i), bus_if.in_ready, 0);
         check($sformatf("v%0d idle_per_en", i), bus_if.per_en, 0);
      end
      bus_if.in_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " in_ready"}, bus_if.in_ready, 0);
      check({tag, " per_en"}, bus_if.per_en, 0);
      check({tag, " per_we"}, bus_if.per_we, 0);
      check({tag, " per_addr"}, bus_if.per_addr, 0);
      check({tag, " per_din"}, bus_if.per_din, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " meta_valid"}, meta_valid, 0);
      check({tag, " hdr_err"}, hdr_err, 0);
      check({tag, " chk_err"}, chk_err, 0);
      check({tag, " blocks_loaded"}, blocks_loaded, 0);
   endtask

   task automatic reset_mid_frame();
      logic [7:0] fb [4];
      int         ptr;
      fb[0] = 8'h01; fb[1] = 8'h34; fb[2] = 8'h12; fb[3] = 8'h78;
      ptr = 0;
      @(negedge mclk);
      load_start = 1'b1;
      @(negedge mclk);
      load_start = 1'b0;
      for (int c = 0; c < 12 && ptr < 4; c++) begin
         if (c > 0) @(negedge mclk);
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = fb[ptr];
         bus_if.bus_gnt  = 1'b1;
         #1;
         if (bus_if.in_ready) ptr = ptr + 1;
      end
      check("rst_mid feed_bytes", ptr, 4);
      @(negedge mclk);
      bus_if.in_valid = 1'b0;
      puc_rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge mclk);
      puc_rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge mclk);
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = 8'h56;
         #1;
         check($sformatf("post_rst c%0d per_en", c), bus_if.per_en, 0);
         check($sformatf("post_rst c%0d in_ready", c), bus_if.in_ready, 0);
         check($sformatf("post_rst c%0d busy", c), busy, 0);
      end
      bus_if.in_valid = 1'b0;
   endtask

   initial begin
      puc_rst_n       = 1'b1;
      load_start      = 1'b0;
      bus_if.in_data  = 8'h00;
      bus_if.in_valid = 1'b0;
      bus_if.bus_gnt  = 1'b1;
      fill_table();
      #2;
      puc_rst_n = 1'b0;
      #1;
      check_reset_outputs("reset");
      @(negedge mclk);
      @(negedge mclk);
      puc_rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(i);

      reset_mid_frame();
      run_vec(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
